// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types and constants for the LIF neuron array
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic LEAK_SUB   = 1'b0;
  localparam logic LEAK_SHIFT = 1'b1;

endpackage

// File: rtl/lif_if.sv
// rtl/lif_if.sv - control, configuration and result bundle of the LIF neuron array
interface lif_if #(
  parameter int WIDTH       = 8,
  parameter int NUM_NEURONS = 4,
  parameter int REFW        = 4
);
  localparam int IDXW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  logic                         tick;
  logic [NUM_NEURONS*WIDTH-1:0] current;
  logic [WIDTH-1:0]             external_input;
  logic [WIDTH-1:0]             threshold;
  logic [WIDTH-1:0]             leak;
  logic                         leak_mode;
  logic [REFW-1:0]              refractory_period;
  logic [IDXW-1:0]              rd_idx;
  logic [WIDTH-1:0]             rd_state;
  logic                         busy;
  logic [NUM_NEURONS-1:0]       spike;
  logic                         spike_valid;
  logic                         overrun;

  modport master (
    output tick, current, external_input, threshold, leak, leak_mode,
           refractory_period, rd_idx,
    input  rd_state, busy, spike, spike_valid, overrun
  );

  modport slave (
    input  tick, current, external_input, threshold, leak, leak_mode,
           refractory_period, rd_idx,
    output rd_state, busy, spike, spike_valid, overrun
  );
endinterface

// File: rtl/lif_update.sv
// rtl/lif_update.sv - combinational single-neuron leak/integrate/fire step
module lif_update
  import lif_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int REFW  = 4
) (
  input  logic [WIDTH-1:0] v,
  input  logic [REFW-1:0]  r,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] ext,
  input  logic [WIDTH-1:0] threshold,
  input  logic [WIDTH-1:0] leak,
  input  logic             leak_mode,
  input  logic [REFW-1:0]  refractory_period,
  output logic [WIDTH-1:0] v_next,
  output logic [REFW-1:0]  r_next,
  output logic             spike
);

  logic [WIDTH-1:0] vl;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] sum_sat;

  always_comb begin
    vl      = '0;
    sum     = '0;
    sum_sat = '0;
    v_next  = v;
    r_next  = r;
    spike   = 1'b0;

    if (leak_mode == LEAK_SHIFT) begin
      vl = v - (v >> leak[3:0]);
    end else begin
      vl = (v > leak) ? (v - leak) : '0;
    end

    // Two guard bits hold vl + cur + ext without wrap before clamping.
    sum     = {2'b00, vl} + {2'b00, cur} + {2'b00, ext};
    sum_sat = (sum[WIDTH+1:WIDTH] != 2'b00) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

    if (r != '0) begin
      r_next = r - REFW'(1);
      v_next = '0;
    end else if (sum_sat >= threshold) begin
      spike  = 1'b1;
      v_next = '0;
      r_next = refractory_period;
    end else begin
      v_next = sum_sat;
      r_next = '0;
    end
  end

endmodule

// File: rtl/lif_array.sv
// rtl/lif_array.sv - time-multiplexed LIF neuron array sharing one update datapath
module lif_array
  import lif_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NUM_NEURONS = 4,
  parameter int REFW        = 4
) (
  input logic clk,
  input logic reset,
  lif_if.slave bus
);

  localparam int IDXW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  state_t                       state;
  logic [IDXW-1:0]              idx;
  logic [NUM_NEURONS*WIDTH-1:0] cur_s;
  logic [WIDTH-1:0]             ext_s;
  logic [WIDTH-1:0]             thr_s;
  logic [WIDTH-1:0]             leak_s;
  logic                         mode_s;
  logic [REFW-1:0]              refp_s;
  logic [WIDTH-1:0]             mem  [NUM_NEURONS];
  logic [REFW-1:0]              refc [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]       spike_acc;

  logic [WIDTH-1:0]             rd_state_q;
  logic                         busy_q;
  logic [NUM_NEURONS-1:0]       spike_q;
  logic                         spike_valid_q;
  logic                         overrun_q;

  logic [WIDTH-1:0]             v_sel;
  logic [REFW-1:0]              r_sel;
  logic [WIDTH-1:0]             cur_sel;
  logic [WIDTH-1:0]             rd_val;
  logic [WIDTH-1:0]             v_next;
  logic [REFW-1:0]              r_next;
  logic                         spike_next;

  // Decoded muxes keep out-of-range indices (non power-of-two counts) reading zero.
  always_comb begin
    v_sel   = '0;
    r_sel   = '0;
    cur_sel = '0;
    rd_val  = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (idx == IDXW'(i)) begin
        v_sel   = mem[i];
        r_sel   = refc[i];
        cur_sel = cur_s[i*WIDTH +: WIDTH];
      end
      if (bus.rd_idx == IDXW'(i)) begin
        rd_val = mem[i];
      end
    end
  end

  lif_update #(
    .WIDTH (WIDTH),
    .REFW  (REFW)
  ) u_update (
    .v                 (v_sel),
    .r                 (r_sel),
    .cur               (cur_sel),
    .ext               (ext_s),
    .threshold         (thr_s),
    .leak              (leak_s),
    .leak_mode         (mode_s),
    .refractory_period (refp_s),
    .v_next            (v_next),
    .r_next            (r_next),
    .spike             (spike_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      cur_s         <= '0;
      ext_s         <= '0;
      thr_s         <= '0;
      leak_s        <= '0;
      mode_s        <= LEAK_SUB;
      refp_s        <= '0;
      spike_acc     <= '0;
      rd_state_q    <= '0;
      busy_q        <= 1'b0;
      spike_q       <= '0;
      spike_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        mem[i]  <= '0;
        refc[i] <= '0;
      end
    end else begin
      spike_valid_q <= 1'b0;
      rd_state_q    <= rd_val;

      case (state)
        IDLE: begin
          if (bus.tick) begin
            cur_s  <= bus.current;
            ext_s  <= bus.external_input;
            thr_s  <= bus.threshold;
            leak_s <= bus.leak;
            mode_s <= bus.leak_mode;
            refp_s <= bus.refractory_period;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= SWEEP;
          end
        end

        SWEEP: begin
          if (bus.tick) overrun_q <= 1'b1;
          for (int i = 0; i < NUM_NEURONS; i++) begin
            if (idx == IDXW'(i)) begin
              mem[i]       <= v_next;
              refc[i]      <= r_next;
              spike_acc[i] <= spike_next;
            end
          end
          if (idx == IDXW'(NUM_NEURONS - 1)) begin
            state <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end

        DONE: begin
          if (bus.tick) overrun_q <= 1'b1;
          spike_q       <= spike_acc;
          spike_valid_q <= 1'b1;
          busy_q        <= 1'b0;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_state    = rd_state_q;
  assign bus.busy        = busy_q;
  assign bus.spike       = spike_q;
  assign bus.spike_valid = spike_valid_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_lif_array.sv
// tb/tb_lif_array.sv - scoreboard bench for the LIF neuron array
module tb_lif_array;

  localparam int W = 8;
  localparam int N = 4;
  localparam int R = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lif_if #(.WIDTH(W), .NUM_NEURONS(N), .REFW(R)) bus ();
  lif_if #(.WIDTH(W), .NUM_NEURONS(5), .REFW(R)) bus5 ();

  lif_array #(.WIDTH(W), .NUM_NEURONS(N), .REFW(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  lif_array #(.WIDTH(W), .NUM_NEURONS(5), .REFW(R)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5)
  );

  typedef struct {
    logic [N-1:0] sp;
    bit           care;
    int           due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.spike_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_spike_valid actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("spike_valid_cycle", cyc, mon_e.due);
        if (mon_e.care) check("spike_vec", bus.spike, mon_e.sp);
      end
    end
  end

  task automatic set_in(input logic [N*W-1:0] cur, input logic [W-1:0] ext,
                        input logic [W-1:0] thr, input logic [W-1:0] lk,
                        input logic md, input logic [R-1:0] rp);
    @(negedge clk);
    bus.current           = cur;
    bus.external_input    = ext;
    bus.threshold         = thr;
    bus.leak              = lk;
    bus.leak_mode         = md;
    bus.refractory_period = rp;
  endtask

  task automatic tick_once(input logic [N-1:0] sp, input bit care);
    exp_t e;
    @(negedge clk);
    bus.tick = 1'b1;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    e.sp   = sp;
    e.care = care;
    e.due  = cyc + N + 1;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL sweep_timeout actual=busy expected=idle (cycle %0d)", cyc);
      exp_q.delete();
    end
  endtask

  task automatic do_reset(input bit with_tick);
    @(negedge clk);
    reset    = 1'b1;
    bus.tick = with_tick;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    bus.tick = 1'b0;
  endtask

  task automatic read_v(input int idx, input int exp, input string name);
    @(negedge clk);
    bus.rd_idx = 2'(idx);
    @(posedge clk);
    #1;
    check(name, bus.rd_state, exp);
  endtask

  task automatic read_v5(input int idx, input int exp);
    @(negedge clk);
    bus5.rd_idx = 3'(idx);
    @(posedge clk);
    #1;
    check("rd_state_n5", bus5.rd_state, exp);
  endtask

  initial begin
    int exp_v[4];
    exp_v = '{50, 99, 148, 197};

    reset                  = 1'b1;
    bus.tick               = 1'b0;
    bus.current            = '0;
    bus.external_input     = '0;
    bus.threshold          = '0;
    bus.leak               = '0;
    bus.leak_mode          = 1'b0;
    bus.refractory_period  = '0;
    bus.rd_idx             = '0;
    bus5.tick              = 1'b0;
    bus5.current           = '0;
    bus5.external_input    = '0;
    bus5.threshold         = '0;
    bus5.leak              = '0;
    bus5.leak_mode         = 1'b0;
    bus5.refractory_period = '0;
    bus5.rd_idx            = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Random activity, then reset mid-sweep with a tick in the reset cycle.
    for (int k = 0; k < 3; k++) begin
      set_in({$urandom(), $urandom()}, W'($urandom()), W'($urandom()),
             W'($urandom_range(0, 15)), 1'($urandom()), R'($urandom()));
      tick_once('0, 1'b0);
      wait_done();
    end
    tick_once('0, 1'b0);
    @(posedge clk);
    do_reset(1'b1);
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_spike", bus.spike, 0);
    check("reset_overrun", bus.overrun, 0);
    for (int i = 0; i < N; i++) read_v(i, 0, "reset_v");
    repeat (10) @(posedge clk);
    #1;
    check("reset_busy_idle", bus.busy, 0);

    // Integrate, fire, refractory hold, resume.
    set_in(32'h0000_0032, 8'd0, 8'd200, 8'd1, 1'b0, 4'd4);
    for (int t = 0; t < 4; t++) begin
      tick_once(4'b0000, 1'b1);
      wait_done();
      read_v(0, exp_v[t], "integrate_v0");
    end
    tick_once(4'b0001, 1'b1);
    wait_done();
    read_v(0, 0, "fire_v0");
    for (int t = 0; t < 4; t++) begin
      tick_once(4'b0000, 1'b1);
      wait_done();
      read_v(0, 0, "refractory_v0");
    end
    tick_once(4'b0000, 1'b1);
    wait_done();
    read_v(0, 50, "resume_v0");

    // Saturation at 255 must still reach a 255 threshold; zero threshold fires all.
    do_reset(1'b0);
    set_in(32'h0000_FF00, 8'd255, 8'd255, 8'd0, 1'b0, 4'd0);
    tick_once(4'b1111, 1'b1);
    wait_done();
    read_v(1, 0, "sat_v1");
    set_in(32'h0, 8'd0, 8'd0, 8'd0, 1'b0, 4'd0);
    tick_once(4'b1111, 1'b1);
    wait_done();

    // Proportional leak.
    do_reset(1'b0);
    set_in(32'h0064_0000, 8'd0, 8'd255, 8'd0, 1'b0, 4'd0);
    tick_once(4'b0000, 1'b1);
    wait_done();
    read_v(2, 100, "shift_load_v2");
    set_in(32'h0, 8'd0, 8'd255, 8'd2, 1'b1, 4'd0);
    tick_once(4'b0000, 1'b1);
    wait_done();
    read_v(2, 75, "shift_v2_1");
    tick_once(4'b0000, 1'b1);
    wait_done();
    read_v(2, 57, "shift_v2_2");
    tick_once(4'b0000, 1'b1);
    wait_done();
    read_v(2, 43, "shift_v2_3");

    // Overrun is sticky; reset mid-sweep aborts without spike_valid.
    do_reset(1'b0);
    set_in(32'h0, 8'd0, 8'd255, 8'd0, 1'b0, 4'd0);
    tick_once(4'b0000, 1'b1);
    @(negedge clk);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    wait_done();
    check("overrun_set", bus.overrun, 1);
    tick_once(4'b0000, 1'b1);
    wait_done();
    check("overrun_sticky", bus.overrun, 1);
    set_in(32'h0000_001E, 8'd0, 8'd255, 8'd0, 1'b0, 4'd0);
    tick_once('0, 1'b0);
    @(posedge clk);
    do_reset(1'b0);
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_overrun", bus.overrun, 0);
    read_v(0, 0, "abort_v0");
    repeat (8) @(posedge clk);

    // Inputs changed mid-sweep must not affect the running timestep.
    set_in(32'h7800_0000, 8'd0, 8'd200, 8'd0, 1'b0, 4'd0);
    tick_once(4'b0000, 1'b1);
    @(negedge clk);
    bus.threshold      = 8'd100;
    bus.external_input = 8'd50;
    bus.current        = '0;
    wait_done();
    read_v(0, 0, "snap_v0");
    read_v(1, 0, "snap_v1");
    read_v(2, 0, "snap_v2");
    read_v(3, 120, "snap_v3");

    // Five-neuron build: neurons 0..3 integrate 10 per tick, neuron 4 idle.
    @(negedge clk);
    bus5.current   = {8'd0, 8'd10, 8'd10, 8'd10, 8'd10};
    bus5.threshold = 8'd255;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      bus5.tick = 1'b1;
      @(negedge clk);
      bus5.tick = 1'b0;
      repeat (10) @(posedge clk);
    end
    for (int i = 0; i < 4; i++) read_v5(i, 20);
    for (int i = 4; i < 8; i++) read_v5(i, 0);

    wait_done();
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
